// File: rtl/feeder_pkg.sv
// Shared west-edge definitions: tile instruction encodings and the feeder FSM states.
package feeder_pkg;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic [1:0] issue_inst(input logic exec_mode);
    return exec_mode ? INST_EXEC : INST_LOAD;
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO; the head is read straight from flop storage, so a
// vector written in one cycle is poppable from the next cycle on.
module vec_fifo
  import feeder_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(depth);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == {(PW+1){1'b0}});
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Simultaneous push and pop cancel out; pointers wrap modulo depth.
    count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= {width{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/array_west_feeder.sv
// West-edge transmitter: buffers row-wide vectors and feeds them into column 0
// of the PE array with row r lagging row 0 by r cycles.
module array_west_feeder
  import feeder_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int depth  = 8,
  parameter int len_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [len_bw-1:0]   len,
  input  logic [row*bw-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [row*bw-1:0]   out_w,
  output logic [row*2-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  localparam int DW = row * bw;
  localparam int CW = $clog2(row);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(row - 2);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [len_bw-1:0]  len_q, len_d;
  logic [len_bw-1:0]  accepted_q, accepted_d;
  logic [len_bw-1:0]  issued_q, issued_d;
  logic [CW-1:0]      drain_q, drain_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               fifo_full, fifo_empty, push, pop;
  logic [DW-1:0]      fifo_head, slot_data;
  logic [1:0]         slot_inst;

  assign in_ready = (state_q == S_RUN) && !fifo_full && (accepted_q < len_q);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_RUN) && !fifo_empty && (issued_q < len_q);
  assign busy     = busy_q;
  assign done     = done_q;

  vec_fifo #(.width(DW), .depth(depth)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    if (pop) begin
      slot_data = fifo_head;
      slot_inst = issue_inst(mode_q);
    end else begin
      slot_data = {DW{1'b0}};
      slot_inst = INST_NOP;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    busy_d     = (state_q != S_IDLE);
    accepted_d = accepted_q + len_bw'(push);
    issued_d   = issued_q + len_bw'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          len_d      = len;
          accepted_d = {len_bw{1'b0}};
          issued_d   = {len_bw{1'b0}};
          drain_d    = {CW{1'b0}};
          state_d    = (len == {len_bw{1'b0}}) ? S_DRAIN : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
          drain_d = {CW{1'b0}};
        end else begin
          state_d = S_RUN;
        end
      end
      // Bubbles keep flowing so the last slot reaches row-1 before done.
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      len_q      <= {len_bw{1'b0}};
      accepted_q <= {len_bw{1'b0}};
      issued_q   <= {len_bw{1'b0}};
      drain_q    <= {CW{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      accepted_q <= accepted_d;
      issued_q   <= issued_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_skew
    logic [bw+1:0] stage_d [r+1];
    logic [bw+1:0] stage_q [r+1];

    // Row r carries only its own element of the slot, delayed r extra cycles.
    always_comb begin
      stage_d[0] = {slot_data[r*bw +: bw], slot_inst};
      for (int k = 1; k <= r; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= r; k++) begin
          stage_q[k] <= {(bw+2){1'b0}};
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign out_w[r*bw +: bw] = stage_q[r][bw+1:2];
    assign inst_w[2*r +: 2]  = stage_q[r][1:0];
  end

endmodule

// File: doc/array_west_feeder.md
Name: array_west_feeder

Overview:
- Transmit side of the systolic-array west-edge protocol.
- Buffers row-wide vectors (weights or activations) arriving over a valid/ready stream.
- Drives in_w data and inst_w[1:0] into the first tile of each row, with the diagonal skew the tile chain expects: row r lags row 0 by r cycles.
- One controller serves the whole west edge; the PE array sits directly east of it.

Parameters:
- bw, 4, bits per element (matches tile bw)
- row, 8, number of array rows driven
- depth, 8, vector FIFO depth (power of two, >=2)
- len_bw, 8, width of the transfer-length field

Ports:
- clk  input  1  clock
- reset  input  1  reset: synchronous, active-high
- start  input  1  one-cycle pulse; begins a transfer (honoured only in IDLE)
- mode  input  1  sampled with start: 0 = kernel load, 1 = execute
- len  input  len_bw  sampled with start: number of vectors in the transfer
- in_data  input  row*bw  vector; element r occupies [r*bw +: bw]
- in_valid  input  1  in_data valid
- in_ready  output  1  feeder accepts in_data this cycle
- out_w  output  row*bw  per-row west data to tile column 0
- inst_w  output  row*2  per-row instruction; bit1 = execute, bit0 = kernel load
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse when the last skewed slot has left row-1

Behaviour:
- Reset: state IDLE. FIFO empty, counters 0, all skew registers 0. Outputs in_ready=0, busy=0, done=0, out_w=0, inst_w=0.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: start latches mode and len.
    - len=0: go to DRAIN directly; done follows after row cycles with no slots issued.
    - Otherwise go to RUN.
  - RUN: ends when issued count reaches len, then go to DRAIN.
  - DRAIN: lasts row-1 cycles, then done=1 for one cycle and return to IDLE.
- start outside IDLE is ignored.
- in_ready = (state==RUN) && !full && (accepted < len).
  - Registered-flag based; no combinational path from in_valid.
  - A handshake writes in_data to the FIFO tail.
- Issue, every RUN cycle:
  - If FIFO is non-empty and issued<len: pop the head. Row-0 slot = {data, inst} with inst = 2'b01 (load) or 2'b10 (execute). issued++.
  - Otherwise: bubble slot {0, 2'b00}.
  - Latency: earliest issue is the cycle after the write (FIFO output registered).
- Skew:
  - out_w/inst_w for row 0 register the row-0 slot.
  - Row r is row 0's slot delayed r cycles: element r of the vector, inst copied.
  - Shift registers keep moving in DRAIN; inputs in DRAIN are bubbles.
- Kernel load ordering: vector k lands in tile column k, because each tile latches the first loaded value and then forwards later ones. len equals the column count; surplus vectors are dropped by the array.
- FIFO full and empty in the same cycle cannot occur. Push and pop in the same cycle keep the count unchanged; wrap-around is natural modulo depth.
- Reset mid-transfer: FIFO and skew pipeline flush immediately, with no done pulse. Tiles must also be reset.

Decomposition:
- Shared package feeder_pkg:
  - Instruction constants INST_NOP=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10 (reused by array-side blocks).
  - FSM state enum {S_IDLE, S_RUN, S_DRAIN}.
- One natural sub-module: vec_fifo (synchronous FIFO, width row*bw, depth depth, full/empty flags, registered head).
- Skew chain and FSM stay in the top module.

Test Plan:
- Execute, row=8, len=3, vectors V0..V2 presented back-to-back:
  - row0 shows V0,V1,V2 with inst 10 on cycles t+1..t+3.
  - row7 shows the same slots on t+8..t+10.
  - done fires one cycle after the row7 slot for V2; busy=0 the cycle after that.
- Load, len=8, element r of vector k = k:
  - row r receives values 0..7 in order with inst 01, skewed by r.
  - After load, a tile model holds weight c in column c.
- Source stalls (in_valid low for 2 cycles between V1 and V2):
  - Two bubble slots with inst 00 and out_w 0 appear between V1 and V2 on every row, correctly skewed.
- depth=8, len=20:
  - in_ready never high while full.
  - Exactly 20 handshakes, 20 issued slots, no loss or duplication across pointer wrap.
- start with len=0 -> no non-NOP slot issued; done pulses exactly once.
- reset asserted mid-RUN after 2 of 5 vectors:
  - Next cycle all outputs 0 and state IDLE, with no done.
  - A new start runs cleanly.
